// File: rtl/featbuf_pkg.sv
// Shared constants, Q4.4 limits and FSM state type for the CMVN feature buffer.
// Rounding mode is selected in cmvn_feat_buffer by FEATBUF_ROUND_EN.
package featbuf_pkg;

  localparam int NUM_FEAT    = 20;
  localparam int NUM_FRAMES  = 50;
  localparam int TOTAL       = NUM_FEAT * NUM_FRAMES;
  localparam int SHIFT       = 20;
  localparam int IN_W        = 32;
  localparam int OUT_W       = 8;
  localparam int FEAT_IDX_W  = 5;
  localparam int FRAME_IDX_W = 6;

  localparam int Q44_MAX = 127;
  localparam int Q44_MIN = -128;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/featbuf_ram.sv
// Single-port synchronous window RAM with write enable and registered read.
// The read register only loads when re is high, so a held address keeps rdata stable.
module featbuf_ram #(
  parameter int DEPTH  = featbuf_pkg::TOTAL,
  parameter int DATA_W = featbuf_pkg::OUT_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cmvn_feat_buffer.sv
// Collects one window of Q8.24 CMVN words as Q4.4 int8, then replays it in order.
// FEATBUF_ROUND_EN defined selects round-half-up; otherwise the quantizer truncates.
//
// state | meaning
// FILL  | accepting input words, writing RAM at wr_cnt
// DRAIN | replaying RAM words 0..TOTAL-1 over the out_* stream
module cmvn_feat_buffer #(
  parameter int NUM_FEAT   = featbuf_pkg::NUM_FEAT,
  parameter int NUM_FRAMES = featbuf_pkg::NUM_FRAMES,
  parameter int IN_W       = featbuf_pkg::IN_W,
  parameter int OUT_W      = featbuf_pkg::OUT_W,
  parameter int SHIFT      = featbuf_pkg::SHIFT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [IN_W-1:0]                     in_data,
  output logic                                in_ready,
  input  logic                                flush,
  output logic                                out_valid,
  output logic [OUT_W-1:0]                    out_data,
  input  logic                                out_ready,
  output logic [featbuf_pkg::FEAT_IDX_W-1:0]  out_feat_idx,
  output logic [featbuf_pkg::FRAME_IDX_W-1:0] out_frame_idx,
  output logic                                out_last,
  output logic                                full
);

  import featbuf_pkg::*;

  localparam int WIN_WORDS = NUM_FEAT * NUM_FRAMES;
  localparam int AW        = $clog2(WIN_WORDS);

  localparam logic [AW-1:0]          LAST_ADDR = AW'(WIN_WORDS - 1);
  localparam logic [FEAT_IDX_W-1:0]  LAST_FEAT = FEAT_IDX_W'(NUM_FEAT - 1);
  localparam logic signed [IN_W:0]   SAT_HI    = (IN_W+1)'(Q44_MAX);
  localparam logic signed [IN_W:0]   SAT_LO    = (IN_W+1)'(Q44_MIN);
`ifdef FEATBUF_ROUND_EN
  localparam logic signed [IN_W:0]   RND_HALF  = (IN_W+1)'(1) <<< (SHIFT - 1);
`endif

  state_t                   state, state_nxt;
  logic [AW-1:0]            wr_cnt;
  logic [AW-1:0]            rd_cnt;
  logic [FEAT_IDX_W-1:0]    rd_feat;
  logic [FRAME_IDX_W-1:0]   rd_frame;

  logic                     accept;
  logic                     retire;
  logic                     last_word;
  logic                     ram_we;
  logic                     ram_re;
  logic [AW-1:0]            ram_addr;
  logic [OUT_W-1:0]         ram_rdata;

  logic signed [IN_W:0]     q_ext;
  logic signed [IN_W:0]     q_sum;
  logic signed [IN_W:0]     q_shr;
  logic [OUT_W-1:0]         q_data;

  // Widened by one bit so the rounding add can never wrap.
  always_comb begin
    q_ext = {in_data[IN_W-1], in_data};
`ifdef FEATBUF_ROUND_EN
    q_sum = q_ext + RND_HALF;
`else
    q_sum = q_ext;
`endif
    q_shr = q_sum >>> SHIFT;
    if (q_shr > SAT_HI) begin
      q_data = SAT_HI[OUT_W-1:0];
    end else if (q_shr < SAT_LO) begin
      q_data = SAT_LO[OUT_W-1:0];
    end else begin
      q_data = q_shr[OUT_W-1:0];
    end
  end

  assign in_ready  = (state == FILL) && !rst;
  assign full      = (state == DRAIN);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign last_word = (rd_cnt == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (accept && wr_cnt == LAST_ADDR) state_nxt = DRAIN;
      DRAIN: if (retire && last_word)           state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
    if (flush) begin
      state_nxt = FILL;
    end
  end

  // Drain reads one word ahead: on a retire the RAM fetches rd_cnt+1, on a stall
  // it re-reads rd_cnt so the registered output does not move.
  always_comb begin
    ram_we   = accept && !flush;
    ram_re   = (state == DRAIN) && !flush && !(retire && last_word);
    ram_addr = wr_cnt;
    if (state == DRAIN) begin
      ram_addr = retire ? (rd_cnt + AW'(1)) : rd_cnt;
    end
  end

  featbuf_ram #(
    .DEPTH  (WIN_WORDS),
    .DATA_W (OUT_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (q_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_feat   <= '0;
      rd_frame  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + AW'(1);
      end
      // First drain cycle issues the read of word 0; data is valid the cycle after.
      if (state == DRAIN && !out_valid) begin
        out_valid <= 1'b1;
      end
      if (retire) begin
        if (last_word) begin
          out_valid <= 1'b0;
          rd_cnt    <= '0;
          rd_feat   <= '0;
          rd_frame  <= '0;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
          if (rd_feat == LAST_FEAT) begin
            rd_feat  <= '0;
            rd_frame <= rd_frame + FRAME_IDX_W'(1);
          end else begin
            rd_feat <= rd_feat + FEAT_IDX_W'(1);
          end
        end
      end
    end
  end

  assign out_data      = ram_rdata;
  assign out_feat_idx  = rd_feat;
  assign out_frame_idx = rd_frame;
  assign out_last      = out_valid && last_word;

endmodule

// File: tb/tb_cmvn_feat_buffer.sv
// Directed bench for cmvn_feat_buffer: quantizer vector table, timing, backpressure,
// flush in fill and drain, and back-to-back windows.
module tb_cmvn_feat_buffer;
  import featbuf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [31:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [4:0] out_feat_idx;
  logic [5:0] out_frame_idx;
  logic       out_last;
  logic       full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  q_rnd;
    logic [7:0]  q_trn;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  cmvn_feat_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .out_feat_idx  (out_feat_idx),
    .out_frame_idx (out_frame_idx),
    .out_last      (out_last),
    .full          (full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ramp_byte(input int mode, input int i);
    int k;
    k = i + ((mode == 3) ? 77 : 0);
    return 8'((k + 128) % 256);
  endfunction

  function automatic logic [31:0] din_of(input int mode, input int i);
    logic [7:0] b;
    b = ramp_byte(mode, i);
    if (mode == 0) return 32'h0180_0000;
    if (mode == 1) return vecs[i % NV].din;
    return {{4{b[7]}}, b, 20'h0};
  endfunction

  function automatic logic [7:0] exp_of(input int mode, input int i);
    if (mode == 0) return 8'h18;
`ifdef FEATBUF_ROUND_EN
    if (mode == 1) return vecs[i % NV].q_rnd;
`else
    if (mode == 1) return vecs[i % NV].q_trn;
`endif
    return ramp_byte(mode, i);
  endfunction

  task automatic fill_window(input int mode);
    chk("fill_start_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < TOTAL; i++) begin
      if (i % 97 == 50) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = din_of(mode, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("n1_full", 32'(full), 32'd1);
    chk("n1_in_ready", 32'(in_ready), 32'd0);
    chk("n1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain_window(input int mode, input bit stall, input int flush_at);
    int   i   = 0;
    int   cyc = 0;
    logic take;
    while (i < TOTAL) begin
      if (cyc >= 8000) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d words required %0d", i, TOTAL);
        break;
      end
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(exp_of(mode, i)));
      chk("drain_feat", 32'(out_feat_idx), 32'(i % NUM_FEAT));
      chk("drain_frame", 32'(out_frame_idx), 32'(i / NUM_FEAT));
      chk("drain_last", 32'(out_last), 32'(i == TOTAL - 1));
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_full", 32'(full), 32'd1);
      if (i == flush_at) begin
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fd_out_valid", 32'(out_valid), 32'd0);
        chk("fd_in_ready", 32'(in_ready), 32'd1);
        chk("fd_full", 32'(full), 32'd0);
        chk("fd_feat", 32'(out_feat_idx), 32'd0);
        chk("fd_frame", 32'(out_frame_idx), 32'd0);
        return;
      end
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      take = out_valid && out_ready;
      @(posedge clk); #1;
      cyc++;
      if (take) i++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("end_in_ready", 32'(in_ready), 32'd1);
    chk("end_out_valid", 32'(out_valid), 32'd0);
    chk("end_full", 32'(full), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0180_0000, 8'h18, 8'h18};
    vecs[1] = '{32'h0900_0000, 8'h7F, 8'h7F};
    vecs[2] = '{32'hF700_0000, 8'h80, 8'h80};
    vecs[3] = '{32'h07F8_0000, 8'h7F, 8'h7F};
    vecs[4] = '{32'h0008_0000, 8'h01, 8'h00};
    vecs[5] = '{32'hFFF8_0000, 8'h00, 8'hFF};
    vecs[6] = '{32'h0000_0000, 8'h00, 8'h00};
    vecs[7] = '{32'hFFE0_0000, 8'hFE, 8'hFE};
    vecs[8] = '{32'h0018_0000, 8'h02, 8'h01};
    vecs[9] = '{32'hFFE8_0000, 8'hFF, 8'hFE};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_feat", 32'(out_feat_idx), 32'd0);
    chk("rst_frame", 32'(out_frame_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic constant window, no backpressure
    fill_window(0);
    drain_window(0, 1'b0, -1);

    // quantizer vector table cycled through a window
    fill_window(1);
    drain_window(1, 1'b0, -1);

    // ramp with random backpressure and junk input traffic during drain
    fill_window(2);
    drain_window(2, 1'b1, -1);

    // flush mid-fill together with an accepted word
    for (int i = 0; i < 500; i++) begin
      in_valid = 1'b1;
      in_data  = din_of(2, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = din_of(2, 500);
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("ff_in_ready", 32'(in_ready), 32'd1);
    chk("ff_full", 32'(full), 32'd0);
    chk("ff_out_valid", 32'(out_valid), 32'd0);
    fill_window(1);
    drain_window(1, 1'b1, -1);

    // flush at drain word 300
    fill_window(2);
    drain_window(2, 1'b0, 300);

    // back-to-back windows with different data
    fill_window(2);
    drain_window(2, 1'b0, -1);
    fill_window(3);
    drain_window(3, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
